// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte transmitter.
// Holds the FSM state encoding, the byte width and the legal divider range.
// The WAIT state exists only when SPI_MASTER_BURST_EN is defined.
package spi_pkg;

    localparam int unsigned SPI_BITS    = 8;
    localparam int unsigned CLK_DIV_MIN = 4;
    localparam int unsigned CLK_DIV_MAX = 255;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned BIT_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
`ifdef SPI_MASTER_BURST_EN
        ,
        ST_WAIT  = 3'd6
`endif
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI transmitter.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   load         - restart a half period (counter := CLK_DIV-1)
//   enable       - count down while high
//   tick_c       - last cycle of the current half period
//   pre_tick_c   - one cycle before tick_c
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
)
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic tick_c,
    output logic pre_tick_c
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Down-counter, auto-reloads on tick so consecutive half periods chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= RELOAD;
        end else if (enable) begin
            if (cnt_q == '0) begin
                cnt_q <= RELOAD;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign tick_c     = enable && (cnt_q == '0);
    assign pre_tick_c = enable && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 byte transmitter (MSB first) with active-low chip select.
// Parameter CLK_DIV: SCK half-period in clk cycles (4..255).
// Macro SPI_MASTER_BURST_EN: adds tx_keep and the WAIT state, which holds
// cs low between bytes.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   tx_data, tx_valid   - byte offer; taken when tx_valid & tx_ready
//   tx_ready            - accepting a byte this cycle (IDLE / WAIT)
//   tx_keep             - keep cs low after this byte (burst build only)
//   sck, cs, mosi       - SPI pins
//   busy                - state is not IDLE
//   done                - one-cycle pulse at the end of each byte
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
`ifdef SPI_MASTER_BURST_EN
    input  logic                tx_keep,
`endif
    output logic                sck,
    output logic                cs,
    output logic                mosi,
    output logic                busy,
    output logic                done
);

    if ((CLK_DIV < CLK_DIV_MIN) || (CLK_DIV > CLK_DIV_MAX)) begin : g_bad_clk_div
        $error("spi_master_tx: CLK_DIV must be within 4..255");
    end

    spi_state_e          state;
    logic [SPI_BITS-2:0] sh_q;      // remaining bits below the one on mosi
    logic [BIT_W-1:0]    bit_cnt;   // HIGH phases completed; bit 0 marks GAP half
    logic                accept_c;
    logic                div_en_c;
    logic                tick_c;
    logic                pre_tick_c;
`ifdef SPI_MASTER_BURST_EN
    logic                keep_q;
`endif

    assign accept_c = tx_valid && tx_ready;

`ifdef SPI_MASTER_BURST_EN
    assign div_en_c = (state != ST_IDLE) && (state != ST_WAIT);
`else
    assign div_en_c = (state != ST_IDLE);
`endif

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk        (clk),
        .reset      (reset),
        .load       (accept_c),
        .enable     (div_en_c),
        .tick_c     (tick_c),
        .pre_tick_c (pre_tick_c)
    );

    // Sequencer with registered pin outputs; pins change only on phase ticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sh_q     <= '0;
            bit_cnt  <= '0;
            cs       <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
            keep_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                state    <= ST_SETUP;
                sh_q     <= tx_data[SPI_BITS-2:0];
                mosi     <= tx_data[SPI_BITS-1];
                bit_cnt  <= '0;
                cs       <= 1'b0;
                sck      <= 1'b0;
                tx_ready <= 1'b0;
                busy     <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
                keep_q   <= tx_keep;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        tx_ready <= 1'b1;
                    end
                    ST_SETUP, ST_LOW: begin
                        if (tick_c) begin
                            state <= ST_HIGH;
                            sck   <= 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (tick_c) begin
                            sck     <= 1'b0;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == BIT_W'(SPI_BITS - 1)) begin
                                state <= ST_HOLD;
                            end else begin
                                // Next bit appears together with the falling sck
                                state <= ST_LOW;
                                mosi  <= sh_q[SPI_BITS-2];
                                sh_q  <= {sh_q[SPI_BITS-3:0], 1'b0};
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (tick_c) begin
`ifdef SPI_MASTER_BURST_EN
                            if (keep_q) begin
                                state    <= ST_WAIT;
                                tx_ready <= 1'b1;
                                done     <= 1'b1;
                            end else begin
                                state <= ST_GAP;
                                cs    <= 1'b1;
                                mosi  <= 1'b0;
                            end
`else
                            state <= ST_GAP;
                            cs    <= 1'b1;
                            mosi  <= 1'b0;
`endif
                        end
                    end
                    ST_GAP: begin
                        // Two half periods; done lands on the very last cycle
                        if (pre_tick_c && bit_cnt[0]) begin
                            done <= 1'b1;
                        end
                        if (tick_c) begin
                            if (bit_cnt[0]) begin
                                state    <= ST_IDLE;
                                bit_cnt  <= '0;
                                tx_ready <= 1'b1;
                                busy     <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end
`ifdef SPI_MASTER_BURST_EN
                    ST_WAIT: begin
                        tx_ready <= 1'b1;
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx at CLK_DIV=4.
module tb_spi_master_tx;

    localparam int unsigned DIV = 4;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
`ifdef SPI_MASTER_BURST_EN
    logic       tx_keep;
`endif
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       busy;
    logic       done;

    spi_master_tx #(
        .CLK_DIV (DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
`ifdef SPI_MASTER_BURST_EN
        .tx_keep  (tx_keep),
`endif
        .sck      (sck),
        .cs       (cs),
        .mosi     (mosi),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_bits;
        int         exp_cs_low;
        int         exp_done_cyc;
        int         exp_idle_cyc;
    } vec_t;

    vec_t       vecs [6];
    int         n_vec;
    int         n_err;
    int         rises;
    int         done_cnt;
    int         bad;
    logic [7:0] cap;
    logic       psck;
    logic       pmosi;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance one cycle and observe pins at the falling edge
    task automatic step();
        @(negedge clk);
        if (sck && !psck) begin
            rises++;
            cap = {cap[6:0], mosi};
            if (mosi !== pmosi) bad++;
        end
        if (done) done_cnt++;
        psck  = sck;
        pmosi = mosi;
    endtask

    task automatic clr_counts();
        rises    = 0;
        done_cnt = 0;
        bad      = 0;
        cap      = 8'h00;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300 && !tx_ready; i++) step();
    endtask

    // Offer one byte, scribble tx_data right after accept, run until IDLE
    task automatic run_byte(input logic [7:0] d,
                            output int cs_low, output int done_cyc, output int idle_cyc);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_ready();
        clr_counts();
        cs_low   = 0;
        done_cyc = 0;
        idle_cyc = 0;
        step();
        tx_data  = 8'hFF;
        tx_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (!cs) cs_low++;
            if (done && done_cyc == 0) done_cyc = c;
            if (tx_ready && !busy) begin
                idle_cyc = c;
                break;
            end
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_low;
        int done_cyc;
        int idle_cyc;
        int g1;
        int rdy;
        int cs_hi;
        logic drop;

        n_vec = 0;
        n_err = 0;
        psck  = 1'b0;
        pmosi = 1'b0;
        clr_counts();

        vecs[0] = '{8'hA5, 8'hA5, 68, 76, 77};
        vecs[1] = '{8'h00, 8'h00, 68, 76, 77};
        vecs[2] = '{8'hFF, 8'hFF, 68, 76, 77};
        vecs[3] = '{8'h5A, 8'h5A, 68, 76, 77};
        vecs[4] = '{8'h3C, 8'h3C, 68, 76, 77};
        vecs[5] = '{8'hC3, 8'hC3, 68, 76, 77};

        tx_data  = 8'h00;
        tx_valid = 1'b1;
`ifdef SPI_MASTER_BURST_EN
        tx_keep  = 1'b0;
`endif
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset state, with tx_valid already offered
        step();
        step();
        chk("reset_pins {cs,sck,mosi,rdy,busy,done}",
            int'({cs, sck, mosi, tx_ready, busy, done}), int'(6'b100000));
        reset = 1'b1;
        chk("ready_low_at_release", int'(tx_ready), 0);
        tx_valid = 1'b0;
        step();
        chk("ready_first_cycle", int'(tx_ready), 1);
        chk("idle_pins {cs,sck,busy}", int'({cs, sck, busy}), int'(3'b100));

        // Table of single bytes
        foreach (vecs[i]) begin
            run_byte(vecs[i].data, cs_low, done_cyc, idle_cyc);
            chk($sformatf("v%0d bits", i), int'(cap), int'(vecs[i].exp_bits));
            chk($sformatf("v%0d sck_rises", i), rises, 8);
            chk($sformatf("v%0d mosi_at_rise", i), bad, 0);
            chk($sformatf("v%0d cs_low", i), cs_low, vecs[i].exp_cs_low);
            chk($sformatf("v%0d done_cycle", i), done_cyc, vecs[i].exp_done_cyc);
            chk($sformatf("v%0d idle_cycle", i), idle_cyc, vecs[i].exp_idle_cyc);
            chk($sformatf("v%0d done_pulses", i), done_cnt, 1);
        end

        // Back-to-back 0x00 then 0xFF with tx_valid held
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        wait_ready();
        clr_counts();
        step();
        tx_data = 8'hFF;
        g1   = 0;
        rdy  = 0;
        drop = 1'b0;
        for (int c = 0; c < 400 && done_cnt < 2; c++) begin
            if (drop) tx_valid = 1'b0;
            if (tx_ready) begin
                rdy++;
                drop = 1'b1;
            end
            if (cs && busy && rdy == 0) g1++;
            step();
        end
        tx_valid = 1'b0;
        chk("b2b gap_cs_high", g1, 8);
        chk("b2b ready_cycles", rdy, 1);
        chk("b2b sck_rises", rises, 16);
        chk("b2b second_byte", int'(cap), int'(8'hFF));
        chk("b2b done_pulses", done_cnt, 2);
        chk("b2b mosi_at_rise", bad, 0);
        for (int i = 0; i < 50 && !tx_ready; i++) step();

        // Reset during the 5th HIGH of 0x3C, then 0x81
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        wait_ready();
        clr_counts();
        step();
        tx_valid = 1'b0;
        for (int c = 0; c < 400 && rises < 5; c++) step();
        chk("rst pre_sck_high", int'(sck), 1);
        reset = 1'b0;
        #1;
        chk("rst async {cs,sck}", int'({cs, sck}), int'(2'b10));
        for (int i = 0; i < 6; i++) step();
        chk("rst no_done", done_cnt, 0);
        chk("rst no_more_rises", rises, 5);
        chk("rst held {cs,sck,busy,rdy}", int'({cs, sck, busy, tx_ready}), int'(4'b1000));
        reset = 1'b1;
        run_byte(8'h81, cs_low, done_cyc, idle_cyc);
        chk("post_rst bits", int'(cap), int'(8'h81));
        chk("post_rst sck_rises", rises, 8);
        chk("post_rst done_cycle", done_cyc, 76);
        chk("post_rst cs_low", cs_low, 68);

`ifdef SPI_MASTER_BURST_EN
        // Burst: 0x12 keep=1, 20-cycle stall, then 0x34 keep=0
        tx_data  = 8'h12;
        tx_keep  = 1'b1;
        tx_valid = 1'b1;
        wait_ready();
        clr_counts();
        step();
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        tx_keep  = 1'b0;
        cs_hi = 0;
        for (int c = 0; c < 400 && !(tx_ready && busy); c++) begin
            if (cs) cs_hi++;
            step();
        end
        chk("burst wait {cs,sck,mosi,rdy,busy}",
            int'({cs, sck, mosi, tx_ready, busy}), int'(5'b00011));
        chk("burst first_done", done_cnt, 1);
        chk("burst first_byte", int'(cap), int'(8'h12));
        for (int i = 0; i < 20; i++) begin
            if (cs) cs_hi++;
            step();
        end
        chk("burst still_waiting", int'({tx_ready, busy, cs}), int'(3'b110));
        tx_data  = 8'h34;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        for (int c = 0; c < 400 && done_cnt < 2; c++) begin
            if (cs && rises < 16) cs_hi++;
            step();
        end
        chk("burst cs_high_cycles", cs_hi, 0);
        chk("burst sck_rises", rises, 16);
        chk("burst done_pulses", done_cnt, 2);
        chk("burst second_byte", int'(cap), int'(8'h34));
        chk("burst mosi_at_rise", bad, 0);
        for (int i = 0; i < 50 && !tx_ready; i++) step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
REQ-001 Parameter CLK_DIV, default 8: SCK half-period in clk cycles; legal range 4..255.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 tx_data  input  8  byte to transmit, MSB first.
REQ-005 tx_valid  input  1  tx_data is offered.
REQ-006 tx_ready  output  1  block accepts a byte this cycle.
REQ-007 tx_keep  input  1  keep CS low after this byte; present only with SPI_MASTER_BURST_EN.
REQ-008 sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 cs  output  1  chip select, active-low.
REQ-010 mosi  output  1  serial data out.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse at the end of each byte.

Function
REQ-013 The states SHALL be IDLE, SETUP, HIGH, LOW, HOLD, GAP and, with the macro only, WAIT.
REQ-014 Accept SHALL occur on a clk edge where tx_valid and tx_ready are both 1; tx_ready is 1 only in IDLE (and WAIT); tx_data and tx_keep are registered at accept and later changes are ignored.
REQ-015 From the cycle after accept: cs=0, sck=0, mosi=tx_data[7]; SETUP lasts CLK_DIV cycles.
REQ-016 HIGH: sck=1 for CLK_DIV cycles, mosi stable; after bits 1..7 go to LOW, after bit 8 go to HOLD.
REQ-017 LOW: sck=0, mosi=next lower bit from the first LOW cycle, CLK_DIV cycles, then HIGH.
REQ-018 HOLD: sck=0, cs=0, mosi=bit0 for CLK_DIV cycles; then GAP (or WAIT, per REQ-030).
REQ-019 GAP: cs=1, sck=0, mosi=0 for 2*CLK_DIV cycles; done=1 on the last GAP cycle; then IDLE.
REQ-020 Byte time SHALL be exactly 19*CLK_DIV cycles from the cycle after accept to re-entry of IDLE.
REQ-021 Exactly 8 sck rising edges SHALL occur per byte; mosi SHALL never change in a cycle where sck rises.
REQ-022 A tx_valid assertion during busy SHALL be neither accepted nor lost; it is accepted on IDLE re-entry if still held.
REQ-023 An accept in the first IDLE cycle after GAP SHALL be legal (back-to-back bytes, cs high exactly 2*CLK_DIV cycles).
REQ-024 The bit counter SHALL be 3 bits; the half-period counter SHALL be 8 bits, reload to CLK_DIV-1 and count down; CLK_DIV outside 4..255 SHALL fail elaboration.

Reset
REQ-025 While reset=0: state=IDLE, cs=1, sck=0, mosi=0, tx_ready=0, busy=0, done=0, counters=0.
REQ-026 Reset asserted mid-byte SHALL force cs=1 and sck=0 immediately (asynchronously), with no further sck edge.
REQ-027 tx_ready SHALL rise in the first clk cycle after reset release.

Configuration
REQ-028 The macro SPI_MASTER_BURST_EN SHALL add the tx_keep port and the WAIT state.
REQ-029 Without the macro, behaviour SHALL be identical to tx_keep=0 and no WAIT logic is built.
REQ-030 With the macro, after HOLD of a byte accepted with tx_keep=1: done pulses, the block enters WAIT (cs=0, sck=0, mosi=bit0, tx_ready=1), and an accept in WAIT goes to SETUP with the new bit7 without raising cs.
REQ-031 A reset during WAIT SHALL behave as REQ-026.

Structure
REQ-032 Package spi_pkg SHALL hold the state enum, SPI_BITS=8 and CLK_DIV_MIN=4.
REQ-033 Sub-module spi_clk_div SHALL generate the half-period tick (load/enable in, tick out).

Verification
REQ-034 CLK_DIV=4, send 0xA5 -> mosi sampled at sck rises = 1,0,1,0,0,1,0,1; cs low 68 cycles; done at cycle 76 after accept.
REQ-035 Back-to-back 0x00 then 0xFF with tx_valid held -> second accept on the first IDLE cycle; cs high exactly 8 cycles between bytes.
REQ-036 Reset asserted during the 5th HIGH of 0x3C -> cs=1 and sck=0 the same cycle; no done; next byte 0x81 transmits correctly.
REQ-037 With SPI_MASTER_BURST_EN, 0x12 (keep=1) then 0x34 (keep=0) after a 20-cycle stall -> cs continuously low; 16 sck rises; done pulses twice.
REQ-038 tx_data changed to 0xFF one cycle after accepting 0x5A -> shifted bits still 0x5A.
REQ-039 Elaborate with CLK_DIV=3 -> elaboration error.
